// File: rtl/float_pkg.sv
// Shared definitions for the single_* binary32 operators.
//   EXP_W / FRAC_W : field widths of binary32
//   EXP_MAX        : all-ones exponent (Inf / NaN encodings)
//   QNAN_32        : canonical quiet NaN returned when no operand is a number
//   float32_t      : sign/exp/frac view of a 32-bit pattern
//   float_cls_e    : operand class
//   a_wins()       : signed-magnitude ordering decision for two non-NaN operands
package float_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
  } float32_t;

  typedef enum logic [2:0] {
    NAN,
    INF,
    ZERO,
    DENORM,
    NORMAL
  } float_cls_e;

  // Returns 1 when operand a is the maximum. Mixed signs: the positive side
  // wins (this also makes +0 beat -0). Same sign: larger magnitude wins when
  // positive, smaller when negative. Ties keep a, so equal patterns return a.
  function automatic logic a_wins(input logic sign_a, input logic sign_b,
                                  input logic mag_gt, input logic mag_lt);
    logic win;
    if (sign_a != sign_b) win = ~sign_a;
    else if (!sign_a)     win = ~mag_lt;
    else                  win = ~mag_gt;
    return win;
  endfunction

endpackage

// File: rtl/single_classify.sv
// Combinational binary32 operand classifier.
//   x         : 32-bit binary32 pattern
//   is_nan    : exp all ones, frac non-zero
//   is_inf    : exp all ones, frac zero
//   is_zero   : exp zero, frac zero
//   is_denorm : exp zero, frac non-zero
//   sign/expo/frac : unpacked fields of x
module single_classify
  import float_pkg::*;
(
  input  logic [31:0]       x,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero,
  output logic              is_denorm,
  output logic              sign,
  output logic [EXP_W-1:0]  expo,
  output logic [FRAC_W-1:0] frac
);

  float32_t   f;
  float_cls_e cls;

  assign f = x;

  always_comb begin
    cls = NORMAL;
    if (f.expo == EXP_MAX) begin
      if (f.frac != '0) cls = NAN;
      else              cls = INF;
    end else if (f.expo == '0) begin
      if (f.frac != '0) cls = DENORM;
      else              cls = ZERO;
    end
  end

  assign is_nan    = (cls == NAN);
  assign is_inf    = (cls == INF);
  assign is_zero   = (cls == ZERO);
  assign is_denorm = (cls == DENORM);
  assign sign      = f.sign;
  assign expo      = f.expo;
  assign frac      = f.frac;

endmodule

// File: rtl/single_max.sv
// Registered binary32 maximum (IEEE-754 maxNum), z = max(a, b), 1-cycle latency,
// one operand pair per clock, no handshake.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset, clears z
//   a, b  : binary32 operands
//   z     : registered result
module single_max
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);

  logic              a_nan, a_inf, a_zero, a_denorm, a_sign;
  logic              b_nan, b_inf, b_zero, b_denorm, b_sign;
  logic [EXP_W-1:0]  a_expo, b_expo;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic [30:0]       a_mag, b_mag;
  logic [31:0]       z_d, z_q;

  single_classify u_cls_a (
    .x         (a),
    .is_nan    (a_nan),
    .is_inf    (a_inf),
    .is_zero   (a_zero),
    .is_denorm (a_denorm),
    .sign      (a_sign),
    .expo      (a_expo),
    .frac      (a_frac)
  );

  single_classify u_cls_b (
    .x         (b),
    .is_nan    (b_nan),
    .is_inf    (b_inf),
    .is_zero   (b_zero),
    .is_denorm (b_denorm),
    .sign      (b_sign),
    .expo      (b_expo),
    .frac      (b_frac)
  );

  assign a_mag = {a_expo, a_frac};
  assign b_mag = {b_expo, b_frac};

  always_comb begin
    z_d = a;
    if (a_nan && b_nan) begin
      z_d = QNAN_32;
    end else if (a_nan) begin
      z_d = b;
    end else if (b_nan) begin
      z_d = a;
    end else if (a_inf || b_inf) begin
      // +Inf always wins, -Inf always loses; -Inf vs -Inf keeps a (same bits).
      z_d = ((a_inf && !a_sign) || (b_inf && b_sign)) ? a : b;
    end else if ((a_zero || a_denorm) && (b_zero || b_denorm)) begin
      // Both exponents are zero: the fraction alone orders them exactly,
      // and mixed-sign zeros resolve to +0 through the sign rule.
      z_d = a_wins(a_sign, b_sign, a_frac > b_frac, a_frac < b_frac) ? a : b;
    end else begin
      z_d = a_wins(a_sign, b_sign, a_mag > b_mag, a_mag < b_mag) ? a : b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= '0;
    else        z_q <= z_d;
  end

  assign z = z_q;

endmodule

// File: tb/tb_single_max.sv
module tb_single_max;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic [31:0] z;

  int n_vec;
  int n_bad;

  single_max dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Reference maxNum via a monotone integer key: negative patterns are
  // bit-inverted, positive ones get the top bit set, so unsigned key order
  // equals float order with -0 < +0.
  function automatic logic [31:0] ref_max(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn;
    logic [31:0] kx, ky;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    if (xn && yn) return 32'h7FC00000;
    if (xn) return y;
    if (yn) return x;
    kx = x[31] ? ~x : (x | 32'h80000000);
    ky = y[31] ? ~y : (y | 32'h80000000);
    return (ky > kx) ? y : x;
  endfunction

  task automatic check(input string name, input logic [31:0] exp_z);
    n_vec++;
    if (z !== exp_z) begin
      n_bad++;
      $display("FAIL %s: z=%08h expected %08h", name, z, exp_z);
    end
  endtask

  task automatic apply(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] exp_z, input string name);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check(name, exp_z);
  endtask

  logic [31:0] edges [18];

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 17)];
    return $urandom();
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    edges = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h80000001,
              32'h007FFFFF, 32'h807FFFFF, 32'h00800000, 32'h3F800000,
              32'hBF800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000,
              32'hFF800000, 32'h7FC00000, 32'hFFC00000, 32'h7F800001,
              32'hFFFFFFFF, 32'h7FC00001};

    vecs.push_back('{32'hC0400000, 32'hBF800000, 32'hBF800000, "neg_neg"});
    vecs.push_back('{32'h3F800000, 32'hBF800000, 32'h3F800000, "pos_neg"});
    vecs.push_back('{32'h00000001, 32'h00000000, 32'h00000001, "min_denorm_vs_zero"});
    vecs.push_back('{32'h80000000, 32'h00000000, 32'h00000000, "negz_posz"});
    vecs.push_back('{32'h00000000, 32'h80000000, 32'h00000000, "posz_negz"});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'h80000000, "negz_negz"});
    vecs.push_back('{32'hFF800000, 32'hFF7FFFFF, 32'hFF7FFFFF, "ninf_vs_nmax"});
    vecs.push_back('{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, "pinf_vs_pmax"});
    vecs.push_back('{32'h7FC00001, 32'hC1200000, 32'hC1200000, "qnan_a"});
    vecs.push_back('{32'h40490FDB, 32'h7F800001, 32'h40490FDB, "snan_b"});
    vecs.push_back('{32'hFFC00000, 32'h7FA00000, 32'h7FC00000, "both_nan"});
    vecs.push_back('{32'h80000001, 32'h80000002, 32'h80000001, "neg_denorms"});
    vecs.push_back('{32'h007FFFFF, 32'h00800000, 32'h00800000, "denorm_vs_minnorm"});
    vecs.push_back('{32'hFF800000, 32'h7F800000, 32'h7F800000, "ninf_pinf"});
    vecs.push_back('{32'h80000001, 32'h00000000, 32'h00000000, "negdenorm_vs_posz"});

    rst_n = 1'b0;
    a = 32'h3F800000;
    b = 32'h40000000;
    #1;
    check("reset_async", 32'h00000000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h3F800000, 32'h40000000, 32'h40000000, "first_after_reset");

    foreach (vecs[i]) apply(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].name);

    // Back-to-back stream: every cycle a new pair, each result one clock later.
    for (int i = 0; i < 1200; i++) begin
      logic [31:0] ra, rb;
      ra = pick();
      case ($urandom_range(0, 7))
        0:       rb = ra;
        1:       rb = ra ^ 32'h80000000;
        default: rb = pick();
      endcase
      apply(ra, rb, ref_max(ra, rb), "stream");
    end

    // Reset pulse between edges, then resume.
    apply(32'h3F800000, 32'h40400000, 32'h40400000, "pre_pulse");
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_pulse", 32'h00000000);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_pulse_hold", 32'h00000000);
    apply(32'hC0000000, 32'hC0400000, 32'hC0000000, "resume_1");
    apply(32'h7FC00000, 32'h00000001, 32'h00000001, "resume_2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/single_max.md
Name: single_max

Overview:
- Registered IEEE-754 binary32 maximum unit: z = max(a, b), one new operand pair accepted every clock.
- Sits in the float math component library beside the other single_* operators.
- Free-running datapath with no handshake; the caller streams operands each cycle and samples z.

Parameters:
- None. Format fixed: binary32, 1 sign bit, 8 exponent bits, 23 fraction bits.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst_n  input  1  Asynchronous active-low reset.
- a  input  32  Operand A, binary32 bit pattern.
- b  input  32  Operand B, binary32 bit pattern.
- z  output  32  Registered result, binary32 bit pattern.

Behaviour:
- Reset:
  - While rst_n=0, z=32'h00000000. Asserting rst_n clears z immediately, without waiting for clk.
  - Deassertion is synchronised by the surrounding design.
  - The first valid z appears one clock after the first sampled operands following reset release.
- Latency and throughput:
  - Exactly 1 cycle: a/b sampled at edge N produce z after edge N and hold until edge N+1.
  - Throughput is 1 result per clock.
  - z is driven directly from a flop, with no combinational path from a/b to z.
- Classification of each operand:
  - NaN: exp=8'hFF and frac!=0.
  - Inf: exp=8'hFF and frac=0.
  - Zero: exp=0 and frac=0.
  - Denormal: exp=0 and frac!=0.
  - Normal: everything else.
- Ordering for non-NaN operands:
  - Denormals are compared exactly, with no flush-to-zero.
  - Both positive: the larger {exp,frac} magnitude wins.
  - Both negative: the smaller magnitude wins.
  - Mixed signs: the positive operand wins.
  - ±0: +0 (32'h00000000) is greater than -0 (32'h80000000). max(+0,-0) = max(-0,+0) = +0. max(-0,-0) = -0.
  - Equal bit patterns return that pattern.
  - Infinities: +Inf beats everything non-NaN. -Inf loses to everything non-NaN.
- NaN rules (IEEE-754 maxNum):
  - Exactly one operand NaN: z = the other operand, bit-exact.
  - Both operands NaN: z = canonical quiet NaN 32'h7FC00000.
  - Signalling and quiet NaNs are treated alike; no exception flags are raised.
- Output bit-exactness:
  - In all non-NaN cases z equals one of the inputs bit-for-bit.
  - No rounding or normalisation is applied.
- X handling: unknown inputs need not yield defined output, but reset must always produce 0.

Decomposition:
- Shared package float_pkg holds:
  - Constants: EXP_W=8, FRAC_W=23, QNAN_32=32'h7FC00000, EXP_MAX=8'hFF.
  - A packed struct type for sign/exp/frac.
  - A classification enum: NAN, INF, ZERO, DENORM, NORMAL.
- One natural sub-module, single_classify: combinational, takes 32-bit x, outputs is_nan, is_inf, is_zero, is_denorm and the sign/magnitude fields. It is instantiated twice.
- The comparison/select logic and the output register live in single_max.

Test Plan:
- Reset: hold rst_n=0 with a=3F800000 and b=40000000 → z=00000000. Release, drive the same values → z=40000000 (2.0) one clock later.
- Sign/magnitude:
  - a=C0400000 (-3.0), b=BF800000 (-1.0) → z=BF800000.
  - a=3F800000, b=BF800000 → z=3F800000.
  - a=00000001 (min denormal), b=00000000 → z=00000001.
- Zeros and infinities:
  - a=80000000, b=00000000 → z=00000000.
  - a=80000000, b=80000000 → z=80000000.
  - a=FF800000 (-Inf), b=FF7FFFFF → z=FF7FFFFF.
  - a=7F800000, b=7F7FFFFF → z=7F800000.
- NaNs:
  - a=7FC00001, b=C1200000 → z=C1200000.
  - a=40490FDB, b=7F800001 (sNaN) → z=40490FDB.
  - a=FFC00000, b=7FA00000 → z=7FC00000.
- Streaming: apply a new pair every clock for 1000+ cycles, covering random patterns and edge classes → each z matches the golden maxNum of the pair from the previous cycle, with no bubbles.
- Async reset mid-stream: pulse rst_n low between clock edges → z goes to 00000000 immediately. The next edge after release resumes 1-cycle results.
